// File: rtl/pll_divider_bank.sv
// pll_divider_bank
//   A bank of NUM_CLOCKS integer clock dividers, all driven from refclk. A small
//   control FSM (LOCKING -> LOCKED -> RECONFIG) gates reconfiguration. Each write
//   is a full re-alignment: every channel is cleared together, so all divided
//   clocks rise on the same refclk edge afterwards.
//
// Ports
//   refclk     : in  sole clock; all state updates on its rising edge
//   rst        : in  synchronous, active-high reset
//   cfg_wr     : in  single-cycle divide-ratio write strobe
//   cfg_sel    : in  [2:0] channel index for the write
//   cfg_div    : in  [DIV_WIDTH-1:0] new divide ratio (>= 2)
//   cfg_ready  : out high while a write will be accepted (LOCKED)
//   cfg_err    : out one-cycle pulse after a rejected write
//   outclk     : out [NUM_CLOCKS-1:0] divided clocks
//   locked     : out high while all channels are aligned and stable
module pll_divider_bank #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_sel,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  typedef enum logic [1:0] {
    LOCKING  = 2'd0,
    LOCKED   = 2'd1,
    RECONFIG = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [15:0]          lock_cnt;
  logic                 cfg_valid;
  logic                 wr_accept;
  logic                 wr_reject;
  logic [2:0]           shadow_sel;
  logic [DIV_WIDTH-1:0] shadow_div;
  logic [DIV_WIDTH-1:0] div_q [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt_q [NUM_CLOCKS];

  assign locked    = (state == LOCKED);
  assign cfg_ready = (state == LOCKED);

  assign cfg_valid = ({29'd0, cfg_sel} < 32'(NUM_CLOCKS)) &&
                     (cfg_div >= DIV_WIDTH'(2));
  assign wr_accept = cfg_wr && cfg_ready && cfg_valid;
  assign wr_reject = cfg_wr && cfg_ready && !cfg_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      LOCKING:  if (lock_cnt == 16'(LOCK_CYCLES - 1)) state_nxt = LOCKED;
      LOCKED:   if (wr_accept) state_nxt = RECONFIG;
      RECONFIG: state_nxt = LOCKING;
      default:  state_nxt = LOCKING;
    endcase
  end

  // Control: FSM state, settle counter and error pulse
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= wr_reject;
      if (state == LOCKING)
        lock_cnt <= lock_cnt + 16'd1;
      else if (state == RECONFIG)
        lock_cnt <= '0;
    end
  end

  // Shadow capture of an accepted write; discarded implicitly by reset,
  // because reset leaves the FSM in LOCKING and the shadow is never applied.
  always_ff @(posedge refclk) begin
    if (wr_accept) begin
      shadow_sel <= cfg_sel;
      shadow_div <= cfg_div;
    end
  end

  // Channels: counters freeze and clear in RECONFIG so every channel restarts
  // from the same edge. outclk is derived from the pre-advance count, so it
  // trails the counter by one cycle and all channels rise together right
  // after RECONFIG.
  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (rst) begin
        div_q[i]  <= DIV_WIDTH'(DEFAULT_DIV);
        cnt_q[i]  <= '0;
        outclk[i] <= 1'b0;
      end else if (state == RECONFIG) begin
        cnt_q[i]  <= '0;
        outclk[i] <= 1'b0;
        if (shadow_sel == 3'(i))
          div_q[i] <= shadow_div;
      end else begin
        outclk[i] <= (cnt_q[i] < (div_q[i] >> 1));
        // Wrap at D-1; D never exceeds 2^DIV_WIDTH-1, so D-1 always fits.
        cnt_q[i]  <= (cnt_q[i] == div_q[i] - DIV_WIDTH'(1)) ? '0
                                                             : cnt_q[i] + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pll_divider_bank.sv
// Scoreboard bench for pll_divider_bank. The driver applies one input vector per
// refclk cycle and pushes the outputs a time-based reference model predicts;
// a separate monitor pops and compares after every rising edge.
module tb_pll_divider_bank;

  localparam int NC = 4;
  localparam int DW = 4;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_wr;
  logic [2:0]    cfg_sel;
  logic [DW-1:0] cfg_div;
  logic          cfg_ready;
  logic          cfg_err;
  logic [NC-1:0] outclk;
  logic          locked;

  always #5 refclk = ~refclk;

  pll_divider_bank #(
    .NUM_CLOCKS (NC),
    .DIV_WIDTH  (DW),
    .LOCK_CYCLES(LC),
    .DEFAULT_DIV(2)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .locked   (locked)
  );

  typedef struct packed {
    logic [NC-1:0] clk;
    logic          lk;
    logic          rdy;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: ratios, edges elapsed since the last alignment point
  // (reset or reconfiguration), and a pending accepted write.
  int m_div[NC];
  int m_age;
  bit m_recfg;
  bit m_err;
  int m_sh_sel;
  int m_sh_div;

  function automatic exp_t predict();
    exp_t e;
    e.lk  = !m_recfg && (m_age >= LC);
    e.rdy = e.lk;
    e.err = m_err;
    for (int i = 0; i < NC; i++)
      e.clk[i] = (m_age == 0) ? 1'b0 : (((m_age - 1) % m_div[i]) < (m_div[i] / 2));
    return e;
  endfunction

  task automatic step(input bit r, input bit w, input int s, input int d);
    bit rdy;
    bit ok;
    @(negedge refclk);
    rst     = r;
    cfg_wr  = w;
    cfg_sel = 3'(s);
    cfg_div = DW'(d);
    if (r) begin
      for (int i = 0; i < NC; i++) m_div[i] = 2;
      m_age = 0; m_recfg = 0; m_err = 0;
    end else if (m_recfg) begin
      m_div[m_sh_sel] = m_sh_div;
      m_age = 0; m_recfg = 0; m_err = 0;
    end else begin
      rdy   = (m_age >= LC);
      ok    = (s < NC) && (d >= 2);
      m_err = w && rdy && !ok;
      if (w && rdy && ok) begin
        m_recfg  = 1;
        m_sh_sel = s;
        m_sh_div = d;
      end
      m_age++;
    end
    sb_q.push_back(predict());
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 2);
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge refclk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {outclk, locked, cfg_ready, cfg_err};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t got outclk=%b locked=%b ready=%b err=%b, expected outclk=%b locked=%b ready=%b err=%b",
                   $time, got.clk, got.lk, got.rdy, got.err, e.clk, e.lk, e.rdy, e.err);
        end
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_sel = '0; cfg_div = '0;
    for (int i = 0; i < NC; i++) m_div[i] = 2;
    m_age = 0; m_recfg = 0; m_err = 0; m_sh_sel = 0; m_sh_div = 2;

    repeat (3) step(1, 0, 0, 0);
    idle(24);                          // relock with default ratios
    step(0, 1, 1, 5); idle(40);        // accepted write, realign, relock
    step(0, 1, 5, 3); idle(3);         // bad channel
    step(0, 1, 2, 1); idle(3);         // bad ratio
    step(0, 1, 0, 0); idle(3);
    step(0, 1, 1, 7);                  // accepted; next edge is RECONFIG
    step(1, 0, 0, 0);                  // reset lands on RECONFIG
    step(0, 1, 2, 9); idle(2);         // writes while locking are ignored
    step(0, 1, 3, 6); idle(20);
    step(0, 1, 3, 15); idle(40);       // widest ratio, 7 high / 8 low
    step(0, 1, 0, 2); idle(20);

    repeat (1500) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    idle(1);
    @(negedge refclk);
    @(negedge refclk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_check pending=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
